// File: rtl/mc_rr_arbiter.sv
// mc_rr_arbiter: shares one memory-controller master port among CONNECT_NUM
// requesters. It serves one transaction at a time and picks the next requester
// with a rotating round-robin pointer. It also has a response timeout, a
// one-cycle timeout error pulse and a completed-transaction counter.
module mc_rr_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int CONNECT_NUM = 3,
  parameter int IDX_WIDTH   = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID,
  input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
  input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID,
  input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
  output logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY,
  output logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID,
  output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
  input  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY,
  output logic                              MASTER_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR,
  output logic                              MASTER_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA,
  input  logic                              MASTER_SEND_READY,
  input  logic                              MASTER_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA,
  output logic                              MASTER_RECEIVE_READY,
  output logic                              GRANT_VALID,
  output logic [IDX_WIDTH-1:0]              GRANT_INDEX,
  output logic                              TIMEOUT_ERR,
  output logic [31:0]                       TXN_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Counter is just wide enough to reach TIMEOUT-1; with TIMEOUT=0 it free-runs unused.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]      TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CONNECT_NUM - 1);

  state_t               state, state_nx;
  logic [IDX_WIDTH-1:0] prio, prio_nx;
  logic [IDX_WIDTH-1:0] gidx, gidx_nx;
  logic [TO_W-1:0]      to_cnt, to_cnt_nx;
  logic [31:0]          txn_cnt, txn_nx;
  logic                 to_err, to_err_nx;

  logic [2*CONNECT_NUM-1:0] req_dbl, req_rot;
  logic                     pick_found;
  logic [IDX_WIDTH-1:0]     pick_idx;
  logic [CONNECT_NUM-1:0]   g_onehot;
  logic                     g_addr_vld, g_data_vld, g_send_rdy;
  logic [IDX_WIDTH-1:0]     prio_after;
  int                       a_off, d_off;

  // Wraps (base + ofs) back into the range 0 .. CONNECT_NUM-1.
  function automatic logic [IDX_WIDTH-1:0] wrap_idx(input logic [IDX_WIDTH-1:0] base,
                                                    input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= CONNECT_NUM) s = s - CONNECT_NUM;
    return IDX_WIDTH'(s);
  endfunction

  // Bit k of req_rot is the request of requester (prio + k) mod CONNECT_NUM.
  assign req_dbl = {SLAVE_RECEIVE_ADDR_VALID, SLAVE_RECEIVE_ADDR_VALID};
  assign req_rot = req_dbl >> prio;

  assign g_onehot   = CONNECT_NUM'(1) << gidx;
  assign g_addr_vld = |(SLAVE_RECEIVE_ADDR_VALID & g_onehot);
  assign g_data_vld = |(SLAVE_RECEIVE_DATA_VALID & g_onehot);
  assign g_send_rdy = |(SLAVE_SEND_READY & g_onehot);
  assign prio_after = (gidx == LAST_IDX) ? '0 : gidx + IDX_WIDTH'(1);
  assign a_off      = int'(gidx) * ADDR_WIDTH;
  assign d_off      = int'(gidx) * DATA_WIDTH;

  assign GRANT_VALID = (state != S_IDLE);
  assign GRANT_INDEX = gidx;
  assign TIMEOUT_ERR = to_err;
  assign TXN_COUNT   = txn_cnt;

  // Round-robin pick: the lowest rotated position with a request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = CONNECT_NUM - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(prio, k);
      end
    end
  end

  // Next-state logic, bookkeeping updates and per-state handshake outputs.
  always_comb begin
    state_nx  = state;
    prio_nx   = prio;
    gidx_nx   = gidx;
    to_cnt_nx = to_cnt;
    txn_nx    = txn_cnt;
    to_err_nx = 1'b0;
    SLAVE_RECEIVE_READY    = '0;
    SLAVE_SEND_VALID       = '0;
    SLAVE_SEND_DATA        = '0;
    MASTER_SEND_ADDR_VALID = 1'b0;
    MASTER_SEND_ADDR       = '0;
    MASTER_SEND_DATA_VALID = 1'b0;
    MASTER_SEND_DATA       = '0;
    MASTER_RECEIVE_READY   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          gidx_nx  = pick_idx;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        MASTER_SEND_ADDR_VALID = g_addr_vld;
        MASTER_SEND_DATA_VALID = g_data_vld;
        MASTER_SEND_ADDR       = SLAVE_RECEIVE_ADDR[a_off +: ADDR_WIDTH];
        MASTER_SEND_DATA       = SLAVE_RECEIVE_DATA[d_off +: DATA_WIDTH];
        SLAVE_RECEIVE_READY    = g_onehot & {CONNECT_NUM{MASTER_SEND_READY & g_addr_vld}};
        if (g_addr_vld && MASTER_SEND_READY) begin
          state_nx  = S_WAIT;
          to_cnt_nx = '0;
        end else if (!g_addr_vld) begin
          // Requester withdrew before acceptance: re-arbitrate, pointer untouched.
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        SLAVE_SEND_VALID     = g_onehot & {CONNECT_NUM{MASTER_RECEIVE_VALID}};
        SLAVE_SEND_DATA      = {CONNECT_NUM{MASTER_RECEIVE_DATA}};
        MASTER_RECEIVE_READY = g_send_rdy;
        if (MASTER_RECEIVE_VALID && g_send_rdy) begin
          // A response on the expiry cycle still completes normally.
          state_nx = S_IDLE;
          prio_nx  = prio_after;
          txn_nx   = txn_cnt + 32'd1;
        end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          state_nx  = S_IDLE;
          prio_nx   = prio_after;
          to_err_nx = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and bookkeeping registers; reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      prio    <= '0;
      gidx    <= '0;
      to_cnt  <= '0;
      txn_cnt <= '0;
      to_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      prio    <= prio_nx;
      gidx    <= gidx_nx;
      to_cnt  <= to_cnt_nx;
      txn_cnt <= txn_nx;
      to_err  <= to_err_nx;
    end
  end

endmodule

// File: tb/tb_mc_rr_arbiter.sv
// Testbench for mc_rr_arbiter: directed scenarios followed by randomized
// transactions, compared against a round-robin reference model.
module tb_mc_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 3;
  localparam int IW = 2;
  localparam int TO = 8;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [N-1:0]    av = '0, dv = '0, ssr = '0;
  logic [AW*N-1:0] addr_bus = '0;
  logic [DW*N-1:0] wdata_bus = '0;
  logic            msr = 1'b0, mrv = 1'b0;
  logic [DW-1:0]   mrd = '0;

  logic [N-1:0]    SLAVE_RECEIVE_READY, SLAVE_SEND_VALID;
  logic [DW*N-1:0] SLAVE_SEND_DATA;
  logic            MASTER_SEND_ADDR_VALID, MASTER_SEND_DATA_VALID, MASTER_RECEIVE_READY;
  logic [AW-1:0]   MASTER_SEND_ADDR;
  logic [DW-1:0]   MASTER_SEND_DATA;
  logic            GRANT_VALID, TIMEOUT_ERR;
  logic [IW-1:0]   GRANT_INDEX;
  logic [31:0]     TXN_COUNT;

  int          errors = 0;
  int          checks = 0;
  int          m_prio = 0;
  int unsigned m_txn  = 0;

  mc_rr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N), .IDX_WIDTH(IW), .TIMEOUT(TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .SLAVE_RECEIVE_ADDR_VALID(av), .SLAVE_RECEIVE_ADDR(addr_bus),
    .SLAVE_RECEIVE_DATA_VALID(dv), .SLAVE_RECEIVE_DATA(wdata_bus),
    .SLAVE_RECEIVE_READY(SLAVE_RECEIVE_READY), .SLAVE_SEND_VALID(SLAVE_SEND_VALID),
    .SLAVE_SEND_DATA(SLAVE_SEND_DATA), .SLAVE_SEND_READY(ssr),
    .MASTER_SEND_ADDR_VALID(MASTER_SEND_ADDR_VALID), .MASTER_SEND_ADDR(MASTER_SEND_ADDR),
    .MASTER_SEND_DATA_VALID(MASTER_SEND_DATA_VALID), .MASTER_SEND_DATA(MASTER_SEND_DATA),
    .MASTER_SEND_READY(msr), .MASTER_RECEIVE_VALID(mrv), .MASTER_RECEIVE_DATA(mrd),
    .MASTER_RECEIVE_READY(MASTER_RECEIVE_READY), .GRANT_VALID(GRANT_VALID),
    .GRANT_INDEX(GRANT_INDEX), .TIMEOUT_ERR(TIMEOUT_ERR), .TXN_COUNT(TXN_COUNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: first requesting index scanning p, p+1, ... modulo N.
  function automatic int exp_grant(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet_inputs();
    av = '0; dv = '0; ssr = '0; msr = 1'b0; mrv = 1'b0;
  endtask

  task automatic pulse_reset();
    quiet_inputs();
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    m_prio = 0;
    m_txn  = 0;
    tick();
  endtask

  task automatic test_reset();
    av = '1; dv = '1; ssr = '1; msr = 1'b1; mrv = 1'b1; mrd = 32'hDEADBEEF;
    repeat (2) @(posedge CLK);
    #2;
    checks++; if (GRANT_VALID !== 1'b0) begin errors++; $display("FAIL rst_grant_valid got=%0h exp=0", GRANT_VALID); end
    checks++; if (GRANT_INDEX !== '0) begin errors++; $display("FAIL rst_grant_index got=%0h exp=0", GRANT_INDEX); end
    checks++; if (TXN_COUNT !== 32'd0) begin errors++; $display("FAIL rst_txn_count got=%0h exp=0", TXN_COUNT); end
    checks++; if (TIMEOUT_ERR !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got=%0h exp=0", TIMEOUT_ERR); end
    checks++; if ({SLAVE_RECEIVE_READY, SLAVE_SEND_VALID, MASTER_SEND_ADDR_VALID, MASTER_SEND_DATA_VALID, MASTER_RECEIVE_READY} !== '0)
      begin errors++; $display("FAIL rst_valid_ready got=%0h exp=0", {SLAVE_RECEIVE_READY, SLAVE_SEND_VALID, MASTER_SEND_ADDR_VALID, MASTER_SEND_DATA_VALID, MASTER_RECEIVE_READY}); end
    checks++; if ({MASTER_SEND_ADDR, MASTER_SEND_DATA, SLAVE_SEND_DATA} !== '0)
      begin errors++; $display("FAIL rst_data_outputs got=%0h exp=0", {MASTER_SEND_ADDR, MASTER_SEND_DATA, SLAVE_SEND_DATA}); end
    quiet_inputs();
    RST_N = 1'b1;
    m_prio = 0;
    m_txn  = 0;
    tick();
  endtask

  task automatic test_basic();
    logic [AW-1:0] a;
    logic [DW-1:0] d, r;
    a = $urandom; d = $urandom; r = $urandom;
    av = 3'b001; dv = 3'b001; addr_bus[0 +: AW] = a; wdata_bus[0 +: DW] = d; msr = 1'b1;
    #1;
    checks++; if (SLAVE_RECEIVE_READY !== 3'b000) begin errors++; $display("FAIL idle_no_ready got=%0h exp=0", SLAVE_RECEIVE_READY); end
    tick();
    checks++; if (GRANT_INDEX !== 2'd0) begin errors++; $display("FAIL basic_grant got=%0h exp=0", GRANT_INDEX); end
    checks++; if (SLAVE_RECEIVE_READY !== 3'b001) begin errors++; $display("FAIL basic_recv_ready got=%0h exp=1", SLAVE_RECEIVE_READY); end
    checks++; if (MASTER_SEND_ADDR !== a) begin errors++; $display("FAIL basic_addr got=%0h exp=%0h", MASTER_SEND_ADDR, a); end
    checks++; if (MASTER_SEND_DATA !== d) begin errors++; $display("FAIL basic_wdata got=%0h exp=%0h", MASTER_SEND_DATA, d); end
    tick();
    av = '0; mrv = 1'b1; mrd = r; ssr = 3'b001;
    #1;
    checks++; if (SLAVE_SEND_VALID !== 3'b001) begin errors++; $display("FAIL basic_send_valid got=%0h exp=1", SLAVE_SEND_VALID); end
    checks++; if (SLAVE_SEND_DATA[0 +: DW] !== r) begin errors++; $display("FAIL basic_rdata got=%0h exp=%0h", SLAVE_SEND_DATA[0 +: DW], r); end
    checks++; if (MASTER_RECEIVE_READY !== 1'b1) begin errors++; $display("FAIL basic_recv_rdy got=%0h exp=1", MASTER_RECEIVE_READY); end
    tick();
    m_txn++; m_prio = 1;
    mrv = 1'b0; ssr = '0;
    checks++; if (TXN_COUNT !== 32'(m_txn)) begin errors++; $display("FAIL basic_txn got=%0d exp=%0d", TXN_COUNT, m_txn); end
    // Pointer is now 1, so requesters 0 and 2 together must yield 2.
    av = 3'b101; msr = 1'b0;
    tick();
    checks++; if (GRANT_INDEX !== IW'(exp_grant(3'b101, m_prio))) begin errors++; $display("FAIL basic_prio got=%0h exp=%0h", GRANT_INDEX, exp_grant(3'b101, m_prio)); end
    av = '0;
    tick();
    checks++; if (GRANT_VALID !== 1'b0) begin errors++; $display("FAIL withdraw_idle got=%0h exp=0", GRANT_VALID); end
  endtask

  task automatic test_rr_wrap();
    int eg;
    pulse_reset();
    av = '1; dv = '1; msr = 1'b1; mrv = 1'b1; ssr = '1;
    for (int i = 0; i < 6; i++) begin
      eg = exp_grant(av, m_prio);
      tick();
      checks++; if (GRANT_INDEX !== IW'(eg)) begin errors++; $display("FAIL rr_grant_%0d got=%0h exp=%0h", i, GRANT_INDEX, eg); end
      tick();
      tick();
      m_prio = (eg + 1) % N;
      m_txn++;
    end
    checks++; if (TXN_COUNT !== 32'(m_txn)) begin errors++; $display("FAIL rr_txn got=%0d exp=%0d", TXN_COUNT, m_txn); end
    quiet_inputs();
  endtask

  task automatic test_issue_stall();
    av = 3'b010; dv = 3'b010; msr = 1'b0;
    addr_bus[AW +: AW] = $urandom;
    tick();
    av = 3'b111;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({GRANT_VALID, GRANT_INDEX, SLAVE_RECEIVE_READY} !== {1'b1, 2'd1, 3'b000})
        begin errors++; $display("FAIL stall_cycle_%0d got=%0h exp=%0h", i, {GRANT_VALID, GRANT_INDEX, SLAVE_RECEIVE_READY}, {1'b1, 2'd1, 3'b000}); end
      tick();
    end
    msr = 1'b1;
    #1;
    checks++; if (SLAVE_RECEIVE_READY !== 3'b010) begin errors++; $display("FAIL stall_release got=%0h exp=2", SLAVE_RECEIVE_READY); end
    checks++; if (MASTER_SEND_ADDR !== addr_bus[AW +: AW]) begin errors++; $display("FAIL stall_addr got=%0h exp=%0h", MASTER_SEND_ADDR, addr_bus[AW +: AW]); end
    tick();
  endtask

  task automatic test_wait_backpressure();
    av = 3'b101; msr = 1'b0; mrv = 1'b1; mrd = $urandom; ssr = 3'b101;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({SLAVE_SEND_VALID, MASTER_RECEIVE_READY} !== {3'b010, 1'b0})
        begin errors++; $display("FAIL bp_cycle_%0d got=%0h exp=4", i, {SLAVE_SEND_VALID, MASTER_RECEIVE_READY}); end
      tick();
    end
    ssr = 3'b111;
    #1;
    checks++; if (MASTER_RECEIVE_READY !== 1'b1) begin errors++; $display("FAIL bp_release got=%0h exp=1", MASTER_RECEIVE_READY); end
    tick();
    m_txn++; m_prio = 2;
    mrv = 1'b0; ssr = '0;
    checks++; if ({GRANT_VALID, TXN_COUNT} !== {1'b0, 32'(m_txn)}) begin errors++; $display("FAIL bp_done got=%0h exp=%0h", {GRANT_VALID, TXN_COUNT}, {1'b0, 32'(m_txn)}); end
  endtask

  task automatic test_timeout();
    int eg;
    eg = exp_grant(av, m_prio);
    msr = 1'b1;
    tick();
    checks++; if (GRANT_INDEX !== IW'(eg)) begin errors++; $display("FAIL to_grant got=%0h exp=%0h", GRANT_INDEX, eg); end
    tick();
    msr = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      tick();
      checks++; if ({TIMEOUT_ERR, GRANT_VALID} !== {c == TO, c != TO})
        begin errors++; $display("FAIL to_cycle_%0d got=%0h exp=%0h", c, {TIMEOUT_ERR, GRANT_VALID}, {c == TO, c != TO}); end
    end
    checks++; if (TXN_COUNT !== 32'(m_txn)) begin errors++; $display("FAIL to_txn got=%0d exp=%0d", TXN_COUNT, m_txn); end
    m_prio = (eg + 1) % N;
    eg = exp_grant(av, m_prio);
    tick();
    checks++; if ({TIMEOUT_ERR, GRANT_INDEX} !== {1'b0, IW'(eg)})
      begin errors++; $display("FAIL to_after got=%0h exp=%0h", {TIMEOUT_ERR, GRANT_INDEX}, {1'b0, IW'(eg)}); end
  endtask

  task automatic test_async_reset();
    msr = 1'b1;
    tick();
    mrv = 1'b1; ssr = '0;
    #1;
    checks++; if (SLAVE_SEND_VALID !== 3'b001) begin errors++; $display("FAIL ar_pre got=%0h exp=1", SLAVE_SEND_VALID); end
    RST_N = 1'b0;
    #1;
    checks++; if ({GRANT_VALID, GRANT_INDEX, SLAVE_SEND_VALID, MASTER_RECEIVE_READY, SLAVE_RECEIVE_READY, MASTER_SEND_ADDR_VALID, TXN_COUNT} !== '0)
      begin errors++; $display("FAIL ar_outputs got=%0h exp=0", {GRANT_VALID, GRANT_INDEX, SLAVE_SEND_VALID, MASTER_RECEIVE_READY, SLAVE_RECEIVE_READY, MASTER_SEND_ADDR_VALID, TXN_COUNT}); end
    #1 RST_N = 1'b1;
    m_prio = 0; m_txn = 0;
    av = 3'b111; msr = 1'b0; ssr = '1;
    tick();
    checks++; if ({GRANT_INDEX, SLAVE_SEND_VALID} !== {2'd0, 3'b000})
      begin errors++; $display("FAIL ar_next got=%0h exp=0", {GRANT_INDEX, SLAVE_SEND_VALID}); end
    quiet_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0]  mask, oh, noise;
    logic [DW-1:0] rd;
    int eg, s, k, last;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      av = mask; dv = N'($urandom); msr = 1'b0; mrv = 1'b0; ssr = '0;
      for (int i = 0; i < N; i++) begin
        addr_bus[i*AW +: AW]  = $urandom;
        wdata_bus[i*DW +: DW] = $urandom;
      end
      eg = exp_grant(mask, m_prio);
      oh = N'(1) << eg;
      tick();
      checks++; if (GRANT_INDEX !== IW'(eg)) begin errors++; $display("FAIL rnd_grant_%0d got=%0h exp=%0h", t, GRANT_INDEX, eg); end
      s = $urandom_range(0, 3);
      for (int i = 0; i < s; i++) begin
        checks++; if (SLAVE_RECEIVE_READY !== '0) begin errors++; $display("FAIL rnd_stall_%0d got=%0h exp=0", t, SLAVE_RECEIVE_READY); end
        tick();
      end
      msr = 1'b1;
      #1;
      checks++; if (SLAVE_RECEIVE_READY !== oh) begin errors++; $display("FAIL rnd_ready_%0d got=%0h exp=%0h", t, SLAVE_RECEIVE_READY, oh); end
      checks++; if ({MASTER_SEND_ADDR, MASTER_SEND_DATA_VALID, MASTER_SEND_DATA} !== {addr_bus[eg*AW +: AW], dv[eg], wdata_bus[eg*DW +: DW]})
        begin errors++; $display("FAIL rnd_issue_%0d got=%0h exp=%0h", t, {MASTER_SEND_ADDR, MASTER_SEND_DATA_VALID, MASTER_SEND_DATA}, {addr_bus[eg*AW +: AW], dv[eg], wdata_bus[eg*DW +: DW]}); end
      tick();
      av = '0; msr = 1'b0; rd = $urandom; mrd = rd;
      // First two rounds pin the expiry boundary: response on the last cycle, then one too late.
      k = (t == 0) ? TO - 1 : (t == 1) ? TO : $urandom_range(0, TO + 1);
      last = (k < TO) ? k : TO - 1;
      for (int w = 0; w <= last; w++) begin
        noise = N'($urandom) & ~oh;
        mrv = (w == k);
        ssr = noise | ((w == k) ? oh : '0);
        #1;
        checks++; if (SLAVE_SEND_VALID !== ((w == k) ? oh : '0)) begin errors++; $display("FAIL rnd_svalid_%0d got=%0h exp=%0h", t, SLAVE_SEND_VALID, (w == k) ? oh : '0); end
        if (w == k) begin
          checks++; if (SLAVE_SEND_DATA[eg*DW +: DW] !== rd) begin errors++; $display("FAIL rnd_rdata_%0d got=%0h exp=%0h", t, SLAVE_SEND_DATA[eg*DW +: DW], rd); end
        end
        tick();
      end
      mrv = 1'b0; ssr = '0;
      if (k < TO) m_txn++;
      m_prio = (eg + 1) % N;
      checks++; if ({GRANT_VALID, TIMEOUT_ERR, TXN_COUNT} !== {1'b0, k >= TO, 32'(m_txn)})
        begin errors++; $display("FAIL rnd_end_%0d got=%0h exp=%0h", t, {GRANT_VALID, TIMEOUT_ERR, TXN_COUNT}, {1'b0, k >= TO, 32'(m_txn)}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr_wrap();
    test_issue_stall();
    test_wait_backpressure();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
